// File: rtl/mips_cpu_muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO.
// Define MULDIV_EARLY_TERM_EN to let MUL stop once the remaining multiplier bits are zero.
module mips_cpu_muldiv_hilo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   // state | meaning
   // IDLE  | waiting for start; MTHI/MTLO complete here
   // MUL   | shift-add, one multiplier bit per cycle
   // DIV   | restoring divide, one quotient bit per cycle
   // FIX   | sign correction and HI/LO write (skipped write on divide by zero)
   // DONE  | one-cycle done pulse
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MUL  = 3'd1;
   localparam logic [2:0] S_DIV  = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [2:0]         state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mpl;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic               neg_q;
   logic               neg_r;
   logic               is_div;
   logic               dbz;

   logic               is_sig;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic               mul_last;

   always_comb begin
      is_sig   = (op == OP_MULT) || (op == OP_DIV);
      abs_a    = (is_sig && A[WIDTH-1]) ? -A : A;
      abs_b    = (is_sig && B[WIDTH-1]) ? -B : B;
      acc_nxt  = acc + (mpl[0] ? mcand : '0);
      rem_sh   = {rem, quo[WIDTH-1]};
      diff     = rem_sh - {1'b0, mpl};
      prod_fix = neg_q ? -acc : acc;
      quo_fix  = neg_q ? -quo : quo;
      rem_fix  = neg_r ? -rem : rem;
   end

`ifdef MULDIV_EARLY_TERM_EN
   // mpl[0] is consumed this cycle; stop when nothing above it is left
   assign mul_last = (cnt == '0) || (mpl[WIDTH-1:1] == '0);
`else
   assign mul_last = (cnt == '0);
`endif

   assign busy        = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
   assign done        = (state == S_DONE);
   assign div_by_zero = (state == S_DONE) && dbz;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mpl    <= '0;
         quo    <= '0;
         rem    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         is_div <= 1'b0;
         dbz    <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, abs_a};
                        mpl    <= abs_b;
                        cnt    <= LAST;
                        neg_q  <= is_sig && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r  <= is_sig && A[WIDTH-1];
                        is_div <= 1'b0;
                        dbz    <= 1'b0;
                        state  <= S_MUL;
                     end
                     OP_DIV, OP_DIVU: begin
                        quo    <= abs_a;
                        rem    <= '0;
                        mpl    <= abs_b;
                        cnt    <= LAST;
                        neg_q  <= is_sig && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r  <= is_sig && A[WIDTH-1];
                        is_div <= 1'b1;
                        dbz    <= (B == '0);
                        // zero divisor passes through FIX without writing HI/LO
                        state  <= (B == '0) ? S_FIX : S_DIV;
                     end
                     OP_MTHI: hi <= A;
                     OP_MTLO: lo <= A;
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               acc   <= acc_nxt;
               mcand <= mcand << 1;
               mpl   <= mpl >> 1;
               cnt   <= cnt - CW'(1);
               if (mul_last) state <= S_FIX;
            end
            S_DIV: begin
               if (!diff[WIDTH]) begin
                  rem <= diff[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= rem_sh[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt - CW'(1);
               if (cnt == '0) state <= S_FIX;
            end
            S_FIX: begin
               if (!dbz) begin
                  if (is_div) begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end else begin
                     hi <= prod_fix[2*WIDTH-1:WIDTH];
                     lo <= prod_fix[WIDTH-1:0];
                  end
               end
               state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mips_cpu_muldiv_hilo.sv
// Directed-vector bench for mips_cpu_muldiv_hilo; latency n counts edges after the start edge.
module tb_mips_cpu_muldiv_hilo;
`ifdef MULDIV_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int errors = 0;
   int checks = 0;

   mips_cpu_muldiv_hilo #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .op          (op),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op, then watch until done; restart_at>0 injects a second start while busy.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edbz, input int restart_at);
      int n;
      int busy_n;
      int held_bad;
      logic [31:0] ohi;
      logic [31:0] olo;
      @(negedge clk);
      ohi = hi;
      olo = lo;
      start = 1'b1;
      op = o;
      A = a;
      B = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = ~a;
      B = ~b;
      n = 0;
      busy_n = 0;
      held_bad = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (done) break;
         if (busy) busy_n++;
         if (hi !== ohi || lo !== olo) held_bad++;
         if (n == restart_at) begin
            start = 1'b1;
            op = o;
            A = 32'd100;
            B = 32'd100;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check({tag, "_lat"}, 64'(n), 64'(lat));
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'(lat - 1));
      check({tag, "_hold"}, 64'(held_bad), 64'd0);
      check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
      check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, edbz});
      check({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
      check({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      start = 1'b0;
      op = 3'd0;
      A = '0;
      B = '0;
      #2;
      check("rst_hi", {32'd0, hi}, 64'd0);
      check("rst_lo", {32'd0, lo}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
      #20;
      @(negedge clk);
      reset_n = 1'b1;

      run_op("mult_m2x3", 3'd0, 32'hFFFFFFFE, 32'h00000003, EARLY ? 4 : 34,
             32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 0);
      run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 34,
             32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
      run_op("mult_m3xm5", 3'd0, 32'hFFFFFFFD, 32'hFFFFFFFB, EARLY ? 5 : 34,
             32'h00000000, 32'h0000000F, 1'b0, 0);
      run_op("div_m7d2", 3'd2, 32'hFFFFFFF9, 32'h00000002, 34,
             32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
      run_op("divu_by0", 3'd3, 32'd100, 32'd0, 2,
             32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 0);
      run_op("divu_100d7", 3'd3, 32'd100, 32'd7, 34,
             32'd2, 32'd14, 1'b0, 0);
      run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 34,
             32'h00000000, 32'h80000000, 1'b0, 0);
      run_op("multu_restart", 3'd1, 32'd7, 32'd9, EARLY ? 6 : 34,
             32'd0, 32'd63, 1'b0, 2);

      // MTHI / MTLO complete in one edge with no busy or done
      @(negedge clk);
      start = 1'b1;
      op = 3'd4;
      A = 32'h12345678;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("mthi_hi", {32'd0, hi}, 64'h12345678);
      check("mthi_lo", {32'd0, lo}, 64'd63);
      check("mthi_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      check("mthi_done", {63'd0, done}, 64'd0);
      start = 1'b1;
      op = 3'd5;
      A = 32'hAABBCCDD;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("mtlo_lo", {32'd0, lo}, 64'hAABBCCDD);
      check("mtlo_busy", {63'd0, busy}, 64'd0);

      @(negedge clk);
      start = 1'b1;
      op = 3'd6;
      A = 32'h0BADF00D;
      B = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("nop_busy", {63'd0, busy}, 64'd0);
      check("nop_done", {63'd0, done}, 64'd0);
      check("nop_hilo", {hi, lo}, {32'h12345678, 32'hAABBCCDD});

      // Asynchronous reset ten edges into a DIVU
      @(negedge clk);
      start = 1'b1;
      op = 3'd3;
      A = 32'd1000;
      B = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("mid_busy_before_rst", {63'd0, busy}, 64'd1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_hi", {32'd0, hi}, 64'd0);
      check("mid_rst_lo", {32'd0, lo}, 64'd0);
      check("mid_rst_busy", {63'd0, busy}, 64'd0);
      check("mid_rst_done", {63'd0, done}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      run_op("multu_5x3", 3'd1, 32'd5, 32'd3, EARLY ? 4 : 34,
             32'd0, 32'd15, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
